// File: rtl/sram_util_pkg.sv
// Helpers shared by SRAM-backed buffers.
// ptr_inc gives the wrapping pointer increment for any depth, not only powers of two.
package sram_util_pkg;

    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sram_generic.sv
// Generic two-port SRAM with registered reads; each q holds its value between reads.
// rstb is a synchronous active-low clear of the array and both read registers.
module sram_generic #(
    parameter int nbits  = 8,
    parameter int nwords = 8,
    localparam int naddrb = $clog2(nwords)
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [naddrb-1:0] addr_1,
    input  logic [nbits-1:0]  data_1,
    input  logic              wren_1,
    input  logic              rden_1,
    output logic [nbits-1:0]  q_1,
    input  logic [naddrb-1:0] addr_2,
    input  logic [nbits-1:0]  data_2,
    input  logic              wren_2,
    input  logic              rden_2,
    output logic [nbits-1:0]  q_2
);

    logic [nbits-1:0] mem_reg [nwords];

    // Port 1 is written last, so it wins when both ports write one address.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int i = 0; i < nwords; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (wren_2) begin
                mem_reg[addr_2] <= data_2;
            end
            if (wren_1) begin
                mem_reg[addr_1] <= data_1;
            end
        end
    end

    // Read-before-write: a same-cycle read returns the previous contents.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            q_1 <= '0;
            q_2 <= '0;
        end else begin
            if (rden_1) begin
                q_1 <= mem_reg[addr_1];
            end
            if (rden_2) begin
                q_2 <= mem_reg[addr_2];
            end
        end
    end

endmodule

// File: rtl/sram_fifo.sv
// Valid/ready FIFO on a two-port SRAM; the SRAM read register is the output stage,
// so out_data is always a held word and capacity is nwords + 1.
module sram_fifo
    import sram_util_pkg::*;
#(
    parameter int nbits  = 8,
    parameter int nwords = 8,
    parameter int afull  = nwords - 1,
    localparam int naddrb = $clog2(nwords),
    localparam int lw     = $clog2(nwords + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [nbits-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [nbits-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [lw-1:0]    level,
    output logic             almost_full
);

    localparam logic [lw-1:0] nwords_c = lw'(nwords);
    localparam logic [lw-1:0] afull_c  = lw'(afull);

    logic [naddrb-1:0] wr_ptr_reg, wr_ptr_next;
    logic [naddrb-1:0] rd_ptr_reg, rd_ptr_next;
    logic [lw-1:0]     mem_count_reg, mem_count_next;
    logic              out_valid_reg, out_valid_next;
    logic              accept;
    logic              rd_issue;
    logic [nbits-1:0]  q_1_unused;

    // in_ready depends on registers only, never on out_ready.
    assign in_ready    = (mem_count_reg < nwords_c);
    assign accept      = in_valid & in_ready;
    assign rd_issue    = (mem_count_reg != '0) & (~out_valid_reg | out_ready);
    assign out_valid   = out_valid_reg;
    assign level       = mem_count_reg + lw'(out_valid_reg);
    assign almost_full = (level >= afull_c);

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        mem_count_next = mem_count_reg;
        out_valid_next = rd_issue | (out_valid_reg & ~out_ready);
        if (accept) begin
            wr_ptr_next = naddrb'(ptr_inc(int'(wr_ptr_reg), nwords));
        end
        if (rd_issue) begin
            rd_ptr_next = naddrb'(ptr_inc(int'(rd_ptr_reg), nwords));
        end
        case ({accept, rd_issue})
            2'b10:   mem_count_next = mem_count_reg + 1'b1;
            2'b01:   mem_count_next = mem_count_reg - 1'b1;
            default: mem_count_next = mem_count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            mem_count_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            mem_count_reg <= mem_count_next;
            out_valid_reg <= out_valid_next;
        end
    end

    sram_generic #(
        .nbits  (nbits),
        .nwords (nwords)
    ) u_mem (
        .clk    (clk),
        .rstb   (~rst),
        .addr_1 (wr_ptr_reg),
        .data_1 (in_data),
        .wren_1 (accept),
        .rden_1 (1'b0),
        .q_1    (q_1_unused),
        .addr_2 (rd_ptr_reg),
        .data_2 ('0),
        .wren_2 (1'b0),
        .rden_2 (rd_issue),
        .q_2    (out_data)
    );

endmodule
